// File: rtl/timer_pkg.sv
// Shared constants for the Timer/Counter1 engine: clock-select codes and
// register bit positions in TCCR1B, TIMSK and TIFR.
package timer_pkg;

   typedef enum logic [2:0] {
      CS_STOP    = 3'b000,
      CS_CLK1    = 3'b001,
      CS_CLK8    = 3'b010,
      CS_CLK64   = 3'b011,
      CS_CLK256  = 3'b100,
      CS_CLK1024 = 3'b101,
      CS_T1_FALL = 3'b110,
      CS_T1_RISE = 3'b111
   } cs_e;

   localparam int WGM12_BIT  = 3;
   localparam int OCIE1A_BIT = 4;
   localparam int TOIE1_BIT  = 2;
   localparam int OCF1A_BIT  = 4;
   localparam int TOV1_BIT   = 2;

   localparam logic [15:0] TCNT_MAX = 16'hFFFF;

endpackage

// File: rtl/timer_prescaler_tick.sv
// Turns the CS1 clock-select code into a single count-enable tick, from either
// the free-running prescaler or a synchronised edge on the external T1 pin.
module timer_prescaler_tick
   import timer_pkg::*;
#(
   parameter int PRESCALE_W = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] cs,
   input  logic       t1_pin,
   output logic       tick
);

   logic [PRESCALE_W-1:0] presc;
   logic                  t1_meta;
   logic                  t1_sync;
   logic                  t1_prev;

   // The prescaler is never cleared by a CS change, so switching divisors
   // keeps the current phase.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc   <= '0;
         t1_meta <= 1'b0;
         t1_sync <= 1'b0;
         t1_prev <= 1'b0;
      end else begin
         presc   <= presc + 1'b1;
         t1_meta <= t1_pin;
         t1_sync <= t1_meta;
         t1_prev <= t1_sync;
      end
   end

   always_comb begin
      tick = 1'b0;
      case (cs_e'(cs))
         CS_STOP:    tick = 1'b0;
         CS_CLK1:    tick = 1'b1;
         CS_CLK8:    tick = &presc[2:0];
         CS_CLK64:   tick = &presc[5:0];
         CS_CLK256:  tick = &presc[7:0];
         CS_CLK1024: tick = &presc[9:0];
         CS_T1_FALL: tick = ~t1_sync & t1_prev;
         CS_T1_RISE: tick = t1_sync & ~t1_prev;
         default:    tick = 1'b0;
      endcase
   end

endmodule

// File: rtl/timer_16bit_count_engine.sv
// Timer/Counter1 count engine: computes the next TCNT1, TIFR set/clear pulses
// and registered interrupt requests from the stored register-file contents.
module timer_16bit_count_engine
   import timer_pkg::*;
#(
   parameter int PRESCALE_W = 10
) (
   input  logic        sysClock,
   input  logic        system_reset,
   input  logic [7:0]  TCCR1B,
   input  logic [15:0] OCR1A,
   input  logic [15:0] TCNT1,
   input  logic [7:0]  TIMSK,
   input  logic [7:0]  TIFR,
   input  logic        cpu_tcnt_write,
   input  logic [15:0] cpu_tcnt_data,
   input  logic        T1_pin,
   input  logic        ocf1a_ack,
   input  logic        tov1_ack,
   output logic [15:0] tcnt_next,
   output logic [7:0]  tifr_set_mask,
   output logic [7:0]  tifr_clr_mask,
   output logic        irq_ocf1a,
   output logic        irq_tov1
);

   logic       tick;
   logic       ctc;
   logic       match;
   logic       at_max;
   logic       cmp_set;
   logic       ovf_set;
   logic       block_cmp;
   logic [7:0] set_d;
   logic [7:0] clr_d;
   logic       unused_bits;

   assign unused_bits = ^{TCCR1B[7:4], TIMSK[7:5], TIMSK[3], TIMSK[1:0],
                          TIFR[7:5], TIFR[3], TIFR[1:0]};

   timer_prescaler_tick #(
      .PRESCALE_W (PRESCALE_W)
   ) u_tick (
      .clk    (sysClock),
      .rst_n  (system_reset),
      .cs     (TCCR1B[2:0]),
      .t1_pin (T1_pin),
      .tick   (tick)
   );

   assign ctc    = TCCR1B[WGM12_BIT];
   assign match  = (TCNT1 == OCR1A);
   assign at_max = (TCNT1 == TCNT_MAX);

   // In CTC the counter only passes MAX when OCR1A sits at MAX itself is
   // excluded, since then the clear-on-match absorbs the wrap.
   assign cmp_set = tick & match & ~block_cmp;
   assign ovf_set = tick & at_max & (~ctc | (OCR1A != TCNT_MAX));

   always_comb begin
      tcnt_next = TCNT1;
      if (!system_reset)
         tcnt_next = '0;
      else if (cpu_tcnt_write)
         tcnt_next = cpu_tcnt_data;
      else if (!tick)
         tcnt_next = TCNT1;
      else if (ctc && match)
         tcnt_next = '0;
      else
         tcnt_next = TCNT1 + 16'd1;
   end

   always_comb begin
      set_d = '0;
      clr_d = '0;
      set_d[OCF1A_BIT] = cmp_set;
      set_d[TOV1_BIT]  = ovf_set;
      clr_d[OCF1A_BIT] = ocf1a_ack & ~cmp_set;
      clr_d[TOV1_BIT]  = tov1_ack & ~ovf_set;
   end

   always_ff @(posedge sysClock) begin
      if (!system_reset) begin
         block_cmp     <= 1'b0;
         tifr_set_mask <= '0;
         tifr_clr_mask <= '0;
         irq_ocf1a     <= 1'b0;
         irq_tov1      <= 1'b0;
      end else begin
         if (cpu_tcnt_write)
            block_cmp <= 1'b1;
         else if (tick)
            block_cmp <= 1'b0;
         tifr_set_mask <= set_d;
         tifr_clr_mask <= clr_d;
         irq_ocf1a     <= TIFR[OCF1A_BIT] & TIMSK[OCIE1A_BIT];
         irq_tov1      <= TIFR[TOV1_BIT] & TIMSK[TOIE1_BIT];
      end
   end

endmodule

// File: tb/tb_timer_16bit_count_engine.sv
// Bench for the Timer1 count engine: emulates the register file around the DUT
// and compares every cycle against a divisor/edge-history reference model.
module tb_timer_16bit_count_engine;

   logic        sysClock = 1'b0;
   logic        system_reset;
   logic [7:0]  TCCR1B;
   logic [15:0] OCR1A;
   logic [15:0] TCNT1;
   logic [7:0]  TIMSK;
   logic [7:0]  TIFR;
   logic        cpu_tcnt_write;
   logic [15:0] cpu_tcnt_data;
   logic        T1_pin;
   logic        ocf1a_ack;
   logic        tov1_ack;
   logic [15:0] tcnt_next;
   logic [7:0]  tifr_set_mask;
   logic [7:0]  tifr_clr_mask;
   logic        irq_ocf1a;
   logic        irq_tov1;

   always #5 sysClock = ~sysClock;

   timer_16bit_count_engine dut (
      .sysClock       (sysClock),
      .system_reset   (system_reset),
      .TCCR1B         (TCCR1B),
      .OCR1A          (OCR1A),
      .TCNT1          (TCNT1),
      .TIMSK          (TIMSK),
      .TIFR           (TIFR),
      .cpu_tcnt_write (cpu_tcnt_write),
      .cpu_tcnt_data  (cpu_tcnt_data),
      .T1_pin         (T1_pin),
      .ocf1a_ack      (ocf1a_ack),
      .tov1_ack       (tov1_ack),
      .tcnt_next      (tcnt_next),
      .tifr_set_mask  (tifr_set_mask),
      .tifr_clr_mask  (tifr_clr_mask),
      .irq_ocf1a      (irq_ocf1a),
      .irq_tov1       (irq_tov1)
   );

   int checks = 0;
   int passes = 0;

   // Values the next applyStimulus call drives onto the DUT.
   logic        rstV, wrV, pinV, ackOV, ackTV;
   logic [7:0]  tccrV, timskV;
   logic [15:0] ocrV, wdataV;

   // Reference model state: cycles since reset, pin samples, write-block flag.
   int unsigned cycleCnt;
   logic        pinHist[$];
   bit          writeBlock;
   logic [7:0]  expSet, expClr;
   logic        expIrqO, expIrqT;

   // Register-file emulation: values seen just before each rising edge.
   logic [15:0] capTcnt;
   logic [7:0]  capSet, capClr;
   logic        capRst;

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      if (observed === expected)
         passes++;
      else
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
                  tag, observed, expected, $time);
   endtask

   function automatic bit modelTick(input logic [2:0] cs);
      bit t1Now, t1Old;
      t1Now = pinHist[1];
      t1Old = pinHist[0];
      case (cs)
         3'd0: return 1'b0;
         3'd1: return 1'b1;
         3'd2: return (cycleCnt % 8) == 7;
         3'd3: return (cycleCnt % 64) == 63;
         3'd4: return (cycleCnt % 256) == 255;
         3'd5: return (cycleCnt % 1024) == 1023;
         3'd6: return !t1Now && t1Old;
         default: return t1Now && !t1Old;
      endcase
   endfunction

   task automatic modelReset();
      cycleCnt   = 0;
      pinHist    = '{1'b0, 1'b0, 1'b0};
      writeBlock = 1'b0;
      expSet     = 8'h00;
      expClr     = 8'h00;
      expIrqO    = 1'b0;
      expIrqT    = 1'b0;
   endtask

   task automatic applyStimulus();
      bit          tk, ctcM, cmp, ovf;
      logic [15:0] expTcnt;
      @(negedge sysClock);
      TCNT1 = capTcnt;
      TIFR  = capRst ? ((TIFR | capSet) & ~capClr) : 8'h00;
      system_reset   = rstV;
      TCCR1B         = tccrV;
      OCR1A          = ocrV;
      TIMSK          = timskV;
      cpu_tcnt_write = wrV;
      cpu_tcnt_data  = wdataV;
      T1_pin         = pinV;
      ocf1a_ack      = ackOV;
      tov1_ack       = ackTV;
      #1;
      tk   = modelTick(tccrV[2:0]);
      ctcM = tccrV[3];
      if (!rstV)
         expTcnt = 16'h0000;
      else if (wrV)
         expTcnt = wdataV;
      else if (!tk)
         expTcnt = TCNT1;
      else if (ctcM && TCNT1 == ocrV)
         expTcnt = 16'h0000;
      else
         expTcnt = TCNT1 + 16'd1;
      checkOutput("tcnt_next", tcnt_next, expTcnt);
      checkOutput("tifr_set_mask", 16'(tifr_set_mask), 16'(expSet));
      checkOutput("tifr_clr_mask", 16'(tifr_clr_mask), 16'(expClr));
      checkOutput("irq_ocf1a", 16'(irq_ocf1a), 16'(expIrqO));
      checkOutput("irq_tov1", 16'(irq_tov1), 16'(expIrqT));
      if (!rstV) begin
         modelReset();
      end else begin
         cmp = tk && (TCNT1 == ocrV) && !writeBlock;
         ovf = tk && (TCNT1 == 16'hFFFF) && (!ctcM || ocrV != 16'hFFFF);
         expSet  = {3'b000, cmp, 1'b0, ovf, 2'b00};
         expClr  = {3'b000, ackOV && !cmp, 1'b0, ackTV && !ovf, 2'b00};
         expIrqO = TIFR[4] & timskV[4];
         expIrqT = TIFR[2] & timskV[2];
         if (wrV)
            writeBlock = 1'b1;
         else if (tk)
            writeBlock = 1'b0;
         cycleCnt++;
         pinHist.push_back(pinV);
         void'(pinHist.pop_front());
      end
      capTcnt = tcnt_next;
      capSet  = tifr_set_mask;
      capClr  = tifr_clr_mask;
      capRst  = system_reset;
   endtask

   task automatic runCycles(input int n);
      for (int k = 0; k < n; k++) applyStimulus();
   endtask

   task automatic cpuWrite(input logic [15:0] value);
      wrV = 1'b1; wdataV = value;
      applyStimulus();
      wrV = 1'b0;
   endtask

   initial begin
      rstV = 1'b0; tccrV = 8'h00; ocrV = 16'h0000; timskV = 8'h00;
      wrV = 1'b0; wdataV = 16'h0000; pinV = 1'b0; ackOV = 1'b0; ackTV = 1'b0;
      system_reset = 1'b0; TCCR1B = 8'h00; OCR1A = 16'h0000; TCNT1 = 16'h0000;
      TIMSK = 8'h00; TIFR = 8'h00; cpu_tcnt_write = 1'b0; cpu_tcnt_data = 16'h0000;
      T1_pin = 1'b0; ocf1a_ack = 1'b0; tov1_ack = 1'b0;
      repeat (3) @(posedge sysClock);
      modelReset();
      capTcnt = 16'h0000; capSet = 8'h00; capClr = 8'h00; capRst = 1'b0;

      // Reset state with noisy inputs.
      tccrV = 8'h09; wrV = 1'b1; wdataV = 16'h1234; ackOV = 1'b1; ackTV = 1'b1;
      runCycles(2);
      wrV = 1'b0; ackOV = 1'b0; ackTV = 1'b0;

      // Normal mode overflow from 0xFFFE.
      rstV = 1'b1; tccrV = 8'h01; ocrV = 16'h8000; timskV = 8'h04;
      cpuWrite(16'hFFFE);
      runCycles(6);
      ackTV = 1'b1; runCycles(1); ackTV = 1'b0; runCycles(3);

      // CTC on OCR1A = 5, acks every cycle to hit coincident set/ack.
      tccrV = 8'h09; ocrV = 16'h0005; timskV = 8'h10;
      cpuWrite(16'h0000);
      runCycles(14);
      ackOV = 1'b1; runCycles(13); ackOV = 1'b0;

      // Write equal to OCR1A blocks only the next compare.
      cpuWrite(16'h0005);
      runCycles(10);

      // clk/8 from a fresh reset, then stopped.
      rstV = 1'b0; runCycles(2);
      rstV = 1'b1; tccrV = 8'h02; ocrV = 16'hFFFF;
      runCycles(20);
      tccrV = 8'h00; runCycles(5);

      // External rising-edge clock with a reset mid-count.
      tccrV = 8'h07;
      for (int k = 0; k < 40; k++) begin
         if (k % 5 == 0) pinV = ~pinV;
         if (k == 22) rstV = 1'b0;
         if (k == 25) rstV = 1'b1;
         applyStimulus();
      end
      tccrV = 8'h06;
      for (int k = 0; k < 20; k++) begin
         if (k % 4 == 0) pinV = ~pinV;
         applyStimulus();
      end

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         if (i % 64 == 0) begin
            tccrV  = 8'($urandom);
            timskV = 8'($urandom);
            case ($urandom_range(0, 2))
               0: ocrV = 16'($urandom_range(0, 20));
               1: ocrV = 16'hFFFF;
               default: ocrV = 16'($urandom);
            endcase
         end
         wrV = ($urandom_range(0, 31) == 0);
         case ($urandom_range(0, 2))
            0: wdataV = ocrV;
            1: wdataV = 16'hFFFF - 16'($urandom_range(0, 3));
            default: wdataV = 16'($urandom);
         endcase
         if ($urandom_range(0, 2) == 0) pinV = ~pinV;
         ackOV = ($urandom_range(0, 3) == 0);
         ackTV = ($urandom_range(0, 3) == 0);
         rstV  = ($urandom_range(0, 499) != 0);
         applyStimulus();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/timer_16bit_count_engine.md
# timer_16bit_count_engine

Counting and flag-generation engine for Timer/Counter1 (16-bit). Consumes the stored contents of TCCR1B, OCR1A, TIMSK, TIFR and TCNT1 from the timer register file and produces the next TCNT1 value, TIFR set/clear masks and interrupt requests. It drives the register file's data inputs and serves the interrupt controller through a request/acknowledge handshake. Supports Normal and CTC modes, internal prescaler and external T1 clocking.

## Interface
- PRESCALE_W, 10, prescaler counter width (covers clk/1024)
- sysClock  in  1  system clock; all state updates on rising edge
- system_reset  in  1  reset is synchronous and active-low
- TCCR1B  in  8  stored control: [2:0] CS1, [3] WGM12 (1 = CTC on OCR1A)
- OCR1A  in  16  stored compare value
- TCNT1  in  16  stored counter value
- TIMSK  in  8  [4] OCIE1A, [2] TOIE1
- TIFR  in  8  [4] OCF1A, [2] TOV1
- cpu_tcnt_write  in  1  CPU writes TCNT1 this cycle
- cpu_tcnt_data  in  16  CPU write value
- T1_pin  in  1  external clock pin, asynchronous
- ocf1a_ack / tov1_ack  in  1  interrupt controller vectored to that source
- tcnt_next  out  16  next TCNT1 value (register file loads every cycle)
- tifr_set_mask  out  8  one-cycle set pulses for TIFR bits
- tifr_clr_mask  out  8  one-cycle clear pulses for TIFR bits
- irq_ocf1a / irq_tov1  out  1  interrupt requests

## Operation
- Clock select CS1: 000 stopped; 001 clk; 010 /8; 011 /64; 100 /256; 101 /1024; 110 T1 falling; 111 T1 rising.
- Prescaler: free-running PRESCALE_W counter, increments every cycle, wraps. tick for /N when low log2(N) bits are all ones. clk/1 tick every cycle.
- T1: two-flop synchronizer then edge-detect flop; edge tick 3 cycles after pin transition.
- tcnt_next priority: cpu_tcnt_write -> cpu_tcnt_data; else no tick -> TCNT1; else CTC and TCNT1 == OCR1A -> 0; else TCNT1 + 1 (16-bit wrap).
- Compare match: on tick with TCNT1 == OCR1A and block_cmp clear -> set OCF1A. Valid in both modes.
- block_cmp: set by cpu_tcnt_write, cleared on the next tick after the write cycle; suppresses only the compare flag for that tick.
- Overflow: Normal mode, tick with TCNT1 == 0xFFFF -> set TOV1. CTC: TOV1 set only when TCNT1 == 0xFFFF and OCR1A != 0xFFFF (counter passes MAX).
- Ack: ocfXa_ack/tov1_ack -> clear pulse on matching TIFR bit.
- Set and ack same cycle for same bit: set wins, clear suppressed.
- irq_ocf1a = TIFR[4] & TIMSK[4]; irq_tov1 = TIFR[2] & TIMSK[2]; registered.
- Unused mask bits always 0.

## Timing
- tcnt_next combinational from registered/stored inputs; TCNT1 reflects tick one cycle later.
- tifr_set_mask / tifr_clr_mask registered: asserted the cycle after the tick/ack, for exactly one cycle.
- irq outputs one cycle behind TIFR/TIMSK; drop one cycle after the clearing pulse lands in TIFR.
- Reset (system_reset low at edge): prescaler 0, synchronizer/edge flops 0, block_cmp 0, masks 0, irqs 0; tcnt_next = 0 while reset low. Reset mid-count discards pending pulses.
- CS change takes effect on the next cycle; prescaler not reset.

## Structure
- Shared package timer_pkg: CS encodings, TIMSK/TIFR bit positions (OCIE1A/OCF1A = 4, TOIE1/TOV1 = 2), WGM12 position.
- Sub-module timer_prescaler_tick: prescaler counter, T1 synchronizer, edge detect, CS mux -> single tick.
- Engine top: next-count mux, compare/overflow detect, block_cmp, ack arbitration, irq registers.

## Test plan
- CS=001, Normal, TCNT1=0xFFFE -> tcnt_next 0xFFFF, then 0x0000 with tifr_set_mask = 0x04 one cycle later.
- CS=001, CTC, OCR1A=0x0005 from 0 -> counts 0..5, wraps to 0; tifr_set_mask = 0x10 once per 6 cycles; never 0x04.
- CS=010 from reset -> tick every 8 cycles (first at cycle 7); CS=000 -> tcnt_next holds.
- CPU writes TCNT1=0x0005 with OCR1A=0x0005, CS=001 -> next tick gives no OCF1A set; match after a later wrap sets it.
- TIMSK=0x10, OCF1A set -> irq_ocf1a high; ocf1a_ack -> tifr_clr_mask 0x10; ack coincident with new match -> set 0x10, clr 0x00.
- CS=111, toggle T1_pin; reset asserted mid-count -> count +1 per rising edge, 3-cycle latency; all outputs 0 during reset.
